bit_permute_pipe: RTL
=====================

// Module: bit_permute_pipe
// PURPOSE
//  Pipelined, mode-selectable bit/byte permutation unit; successor to the combinational bit reverser.
//  Accepts one WIDTH-bit word per cycle over a valid/ready handshake.
//  Applies one of four permutations: full bit reverse, byte swap, per-byte bit reverse, pass-through.
//  Sits between a streaming producer and consumer with full backpressure; 2-cycle latency, 1 word/cycle.
// PARAMETERS
//  WIDTH   32  data width in bits; multiple of 8, >= 8 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      producer presents in_data/in_mode
//  in_ready   out  1      unit can accept this cycle
//  in_data    in   WIDTH  word to permute
//  in_mode    in   2      permutation select, sampled with the word
//  out_valid  out  1      out_data holds a result
//  out_ready  in   1      consumer accepts this cycle
//  out_data   out  WIDTH  permuted word
//  out_mode   out  2      mode the word was processed with
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_mode=0, all internal valids=0; in_ready=1 in the first cycle after reset.
//  Reset mid-operation discards every in-flight word; no output for a word accepted before reset.
//  Transfer on in_valid&in_ready (input) and on out_valid&out_ready (output).
//  Stage S1: registers in_data and in_mode on input transfer. S2: registers perm(S1 data, S1 mode).
//  Readiness: s2_rdy = !s2_v | out_ready; s1_rdy = !s1_v | s2_rdy; in_ready = s1_rdy (combinational).
//  Latency: a word accepted at edge N is presented with out_valid=1 after edge N+2 when there is no stall.
//  Throughput: with out_ready held 1, one word per cycle, no bubbles.
//  Stall: out_valid & !out_ready holds out_data/out_mode stable; S1 fills, then in_ready drops.
//  Simultaneous output pop and input push on a full pipe: both transfers occur; no word is lost or duplicated.
//  Order is strictly FIFO; in_mode applies only to its own word (per-word mode, no sticky state).
//  Modes (i = bit index, k = byte index, B = WIDTH/8):
//   0 BITREV : out[i] = in[WIDTH-1-i]
//   1 BYTESWP: out byte k = in byte B-1-k; bits within a byte unchanged
//   2 BYTEREV: bit order reversed inside each byte; byte positions unchanged
//   3 PASS   : out = in
//  in_data/in_mode are ignored when in_valid=0. out_data is don't-care-stable: it keeps its last value when out_valid=0.
// STRUCTURE
//  Package bitperm_pkg: localparams MODE_BITREV=2'd0, MODE_BYTESWP=2'd1, MODE_BYTEREV=2'd2, MODE_PASS=2'd3.
//  Sub-module bit_permute_core #(WIDTH): purely combinational (data, mode) -> data; instantiated between S1 and S2.
//  Top level: two valid/data/mode register stages plus the ready chain; no FSM beyond per-stage valid bits.
// TESTING (WIDTH=32 unless noted)
//  Reset, then mode0 0x00000001 with out_ready=1 -> out_valid exactly 2 cycles later, out_data=0x80000000, out_mode=0.
//  Back-to-back mode1 0x12345678, mode2 0x01000180, mode3 0xDEADBEEF -> 0x78563412, 0x80008001, 0xDEADBEEF
//   on consecutive cycles, in order.
//  Hold out_ready=0 and stream words -> in_ready drops after exactly 2 accepts; out_data stays stable;
//   releasing out_ready drains both words in order with no loss or duplication.
//  Assert rst while 2 words are in flight -> out_valid=0 on the next cycle; neither word ever appears.
//  1000 random words with random modes, random in_valid and out_ready -> scoreboard against a reference
//   model: exact match and order, zero mismatches (repeat with WIDTH=8 and WIDTH=64).

Source files
------------

// File: rtl/bitperm_pkg.sv
// rtl/bitperm_pkg.sv - shared mode encodings for the bit permutation pipeline
package bitperm_pkg;

    localparam logic [1:0] MODE_BITREV  = 2'd0;
    localparam logic [1:0] MODE_BYTESWP = 2'd1;
    localparam logic [1:0] MODE_BYTEREV = 2'd2;
    localparam logic [1:0] MODE_PASS    = 2'd3;

endpackage

// File: rtl/bit_permute_core.sv
// rtl/bit_permute_core.sv - combinational mode-selected bit/byte permutation
//   data   in   WIDTH  word to permute
//   mode   in   2      permutation select (bitperm_pkg MODE_*)
//   result out  WIDTH  permuted word
module bit_permute_core
    import bitperm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    localparam int BYTES = WIDTH / 8;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("bit_permute_core: WIDTH must be a multiple of 8 and at least 8");
    end

    logic [WIDTH-1:0] bitrev;
    logic [WIDTH-1:0] byteswp;
    logic [WIDTH-1:0] byterev;

    // All three candidate permutations are pure wiring; only the final mux costs logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bitrev[i]  = data[WIDTH-1-i];
        assign byteswp[i] = data[(BYTES-1-(i/8))*8 + (i%8)];
        assign byterev[i] = data[(i/8)*8 + 7 - (i%8)];
    end

    always_comb begin
        result = data;
        case (mode)
            MODE_BITREV:  result = bitrev;
            MODE_BYTESWP: result = byteswp;
            MODE_BYTEREV: result = byterev;
            MODE_PASS:    result = data;
            default:      result = data;
        endcase
    end

endmodule

// File: rtl/bit_permute_pipe.sv
// rtl/bit_permute_pipe.sv - two-stage valid/ready pipelined bit/byte permutation unit
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      producer presents in_data/in_mode
//   in_ready   out  1      unit accepts this cycle
//   in_data    in   WIDTH  word to permute
//   in_mode    in   2      permutation select for this word
//   out_valid  out  1      out_data holds a result
//   out_ready  in   1      consumer accepts this cycle
//   out_data   out  WIDTH  permuted word
//   out_mode   out  2      mode the word was processed with
module bit_permute_pipe
    import bitperm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode
);

    logic             s1_v;
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_mode;
    logic             s1_rdy;
    logic             s2_rdy;
    logic [WIDTH-1:0] perm_data;

    // A stage may load when it is empty or its contents leave this same cycle,
    // so a full pipe with out_ready=1 still takes one word per cycle.
    assign s2_rdy   = !out_valid || out_ready;
    assign s1_rdy   = !s1_v || s2_rdy;
    assign in_ready = s1_rdy;

    bit_permute_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .data   (s1_data),
        .mode   (s1_mode),
        .result (perm_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_BITREV;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_BITREV;
        end else begin
            if (s1_rdy) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_mode <= in_mode;
                end
            end
            // Data registers only load with a real word so out_data holds its
            // last value while out_valid is low.
            if (s2_rdy) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_data <= perm_data;
                    out_mode <= s1_mode;
                end
            end
        end
    end

endmodule
